arith_wake_ctrl: RTL

- Consumer (read side) of the fetch-stage arithmetic lookahead FIFO.
- Watches the hint vector and pops one entry for each instruction the decode stage retires.
- Runs a wake/sleep FSM that enables the arithmetic unit early enough to hide its wake-up latency.
- Stalls decode only when an arithmetic instruction arrives before the unit is ready. Sits between the lookahead FIFO, the decode stage, and the ALU clock/power enable.

---
 rtl/arith_wake_pkg.sv | 22 ++
 rtl/sat_counter.sv | 20 ++
 rtl/arith_wake_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/arith_wake_pkg.sv
// Shared types and sizing helpers for the ALU wake/sleep controller.
// The state encoding is fixed at 2 bits so the decoded enables stay glitch-free.
package arith_wake_pkg;

  typedef enum logic [1:0] {
    SLEEP    = 2'd0,
    WAKE     = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } wake_state_t;

  localparam int DEPTH_DEF       = 4;
  localparam int WAKE_CYCLES_DEF = 2;
  localparam int IDLE_CYCLES_DEF = 8;
  localparam int CNT_W_DEF       = 16;

  // Bits needed to hold n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// One-cycle update latency; no flow control.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/arith_wake_ctrl.sv
// Lookahead-FIFO consumer that wakes the ALU ahead of arithmetic work and pops per retired instruction.
// ALU usable WAKE_CYCLES+1 cycles after first demand; decode is held only for arithmetic ops while not ready.
module arith_wake_ctrl
  import arith_wake_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] hint_bits,
  input  logic             hint_valid,
  input  logic             dec_valid,
  input  logic             dec_is_arith,
  output logic             pop,
  output logic             stall_req,
  output logic             alu_en,
  output logic             alu_ready,
  output logic [CNT_W-1:0] wake_events,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAKE_W = cnt_w(WAKE_CYCLES);
  localparam int IDLE_W = cnt_w(IDLE_CYCLES);

  wake_state_t       state, next_state;
  logic [WAKE_W-1:0] wake_cnt, next_wake_cnt;
  logic [IDLE_W-1:0] idle_cnt, next_idle_cnt;
  logic              demand;
  logic              wake_start;

  assign demand = hint_valid | (dec_valid & dec_is_arith);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SLEEP;
      wake_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= next_state;
      wake_cnt <= next_wake_cnt;
      idle_cnt <= next_idle_cnt;
    end
  end

  always_comb begin
    next_state    = state;
    next_wake_cnt = wake_cnt;
    next_idle_cnt = idle_cnt;
    wake_start    = 1'b0;
    case (state)
      SLEEP: begin
        if (demand) begin
          next_state    = WAKE;
          next_wake_cnt = WAKE_W'(WAKE_CYCLES - 1);
          wake_start    = 1'b1;
        end
      end
      WAKE: begin
        if (wake_cnt == '0) next_state = ACTIVE;
        else                next_wake_cnt = wake_cnt - 1'b1;
      end
      ACTIVE: begin
        if (!demand) begin
          next_state    = COOLDOWN;
          next_idle_cnt = IDLE_W'(IDLE_CYCLES - 1);
        end
      end
      COOLDOWN: begin
        // Fresh demand beats expiry in the same cycle.
        if (demand)              next_state = ACTIVE;
        else if (idle_cnt == '0) next_state = SLEEP;
        else                     next_idle_cnt = idle_cnt - 1'b1;
      end
      default: next_state = SLEEP;
    endcase
  end

  assign alu_en    = (state != SLEEP);
  assign alu_ready = (state == ACTIVE) || (state == COOLDOWN);
  assign stall_req = dec_valid & dec_is_arith & ~alu_ready;
  assign pop       = dec_valid & ~stall_req;

  sat_counter #(.W(CNT_W)) u_wake_events (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wake_start),
    .count (wake_events)
  );

  sat_counter #(.W(CNT_W)) u_stall_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_req),
    .count (stall_cycles)
  );

  // The summary bit must agree with the vector it summarises.
  hint_consistent : assert property (@(posedge clk) disable iff (!rst_n) hint_valid == (|hint_bits));

endmodule
